// File: rtl/idma_data_unalign_256b_if.sv
// idma_data_unalign_256b_if: source/destination beat handshake and alignment offsets for the 256-bit unaligner
interface idma_data_unalign_256b_if;
    logic         f_valid_in;
    logic [255:0] f_data_in;
    logic         f_data_last;
    logic         f_ready_out;
    logic         b_valid_out;
    logic [255:0] b_data_out;
    logic [31:0]  b_strb_out;
    logic         b_data_last;
    logic         b_ready_in;
    logic [4:0]   start_addr;
    logic [4:0]   end_addr;
    modport slave (
        input  f_valid_in, f_data_in, f_data_last, b_ready_in, start_addr, end_addr,
        output f_ready_out, b_valid_out, b_data_out, b_strb_out, b_data_last
    );
    modport master (
        output f_valid_in, f_data_in, f_data_last, b_ready_in, start_addr, end_addr,
        input  f_ready_out, b_valid_out, b_data_out, b_strb_out, b_data_last
    );
endinterface

// File: rtl/idma_data_unalign_256b.sv
// idma_data_unalign_256b: shifts dense source beats to a destination byte offset, with strobes and a spill flush beat.
// Optional IDMA_UNALIGN_BYTECNT_EN adds b_byte_cnt, the strobed-byte count of the current transfer.
module idma_data_unalign_256b (
    input  logic clk,
    input  logic rst,
    idma_data_unalign_256b_if.slave bus
`ifdef IDMA_UNALIGN_BYTECNT_EN
    ,
    output logic [15:0] b_byte_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
    state_e       state_q, state_d;
    logic [255:0] carry_q, carry_d, raw;
    logic [31:0]  strb;
    logic [4:0]   s, e;
    logic         spill, flush, f_hs, b_hs, last_beat;
    assign s = bus.start_addr;
    assign e = bus.end_addr;
    always_comb begin
        flush           = state_q == FLUSH;
        spill           = (s != 5'd0) && (e < s);
        bus.b_valid_out = flush || bus.f_valid_in;
        bus.f_ready_out = !flush && bus.b_ready_in;
        f_hs            = bus.f_valid_in && bus.f_ready_out;
        b_hs            = bus.b_valid_out && bus.b_ready_in;
        last_beat       = flush || (bus.f_data_last && !spill);
        bus.b_data_last = bus.b_valid_out && last_beat;
        raw  = flush ? carry_q : (bus.f_data_in << {s, 3'b000}) | (state_q == RUN ? carry_q : 256'h0);
        strb = (state_q == IDLE ? 32'hffff_ffff << s : 32'hffff_ffff)
             & (last_beat ? 32'hffff_ffff >> (5'd31 - e) : 32'hffff_ffff);
        bus.b_strb_out = strb;
        bus.b_data_out = '0;
        for (int i = 0; i < 32; i++) bus.b_data_out[8*i +: 8] = strb[i] ? raw[8*i +: 8] : 8'h00;
        // shift of 256 for s = 0 yields an all-zero carry
        carry_d = f_hs ? bus.f_data_in >> (9'd256 - {1'b0, s, 3'b000}) : carry_q;
        state_d = state_q;
        if (f_hs) state_d = !bus.f_data_last ? RUN : spill ? FLUSH : IDLE;
        if (flush && b_hs) state_d = IDLE;
    end
`ifdef IDMA_UNALIGN_BYTECNT_EN
    logic [15:0] byte_cnt_q, byte_cnt_d;
    assign b_byte_cnt = byte_cnt_q;
    always_comb begin
        byte_cnt_d = b_hs ? (state_q == IDLE ? 16'd0 : byte_cnt_q) + 16'($countones(strb)) : byte_cnt_q;
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            carry_q <= '0;
`ifdef IDMA_UNALIGN_BYTECNT_EN
            byte_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
`ifdef IDMA_UNALIGN_BYTECNT_EN
            byte_cnt_q <= byte_cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_idma_data_unalign_256b.sv
// tb_idma_data_unalign_256b: directed table of per-cycle vectors plus stall and reset-in-flush sequences.
module tb_idma_data_unalign_256b;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    idma_data_unalign_256b_if bus();
`ifdef IDMA_UNALIGN_BYTECNT_EN
    logic [15:0] byte_cnt;
`endif
    idma_data_unalign_256b dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
`ifdef IDMA_UNALIGN_BYTECNT_EN
        ,
        .b_byte_cnt(byte_cnt)
`endif
    );

    typedef struct {
        logic [4:0]   s, e;
        logic         fv, fl, br;
        logic [255:0] d;
        logic         xbv, xfr, xl;
        logic [255:0] xd;
        logic [31:0]  xs;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;
    logic [255:0] a, b, c;

    function automatic vec_t mk(logic [4:0] s, logic [4:0] e, logic fv, logic [255:0] d, logic fl, logic br,
                                logic xbv, logic xfr, logic xl, logic [255:0] xd, logic [31:0] xs);
        vec_t v;
        v.s = s; v.e = e; v.fv = fv; v.d = d; v.fl = fl; v.br = br;
        v.xbv = xbv; v.xfr = xfr; v.xl = xl; v.xd = xd; v.xs = xs;
        return v;
    endfunction

    task automatic chk(string n, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    task automatic drive(logic [4:0] s, logic [4:0] e, logic fv, logic [255:0] d, logic fl, logic br);
        bus.start_addr = s;
        bus.end_addr = e;
        bus.f_valid_in = fv;
        bus.f_data_in = d;
        bus.f_data_last = fl;
        bus.b_ready_in = br;
    endtask

    task automatic expect_out(string n, logic xbv, logic xfr, logic xl, logic [255:0] xd, logic [31:0] xs);
        chk({n, ".valid"}, 256'(bus.b_valid_out), 256'(xbv));
        chk({n, ".ready"}, 256'(bus.f_ready_out), 256'(xfr));
        chk({n, ".last"}, 256'(bus.b_data_last), 256'(xl));
        if (xbv) begin
            chk({n, ".data"}, bus.b_data_out, xd);
            chk({n, ".strb"}, 256'(bus.b_strb_out), 256'(xs));
        end
    endtask

    task automatic stall_beat(string n, logic fv, logic [255:0] d, logic fl, logic xfr,
                              logic xl, logic [255:0] xd, logic [31:0] xs);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(5'd4, 5'd3, fv, d, fl, 1'b0);
            #1;
            expect_out($sformatf("%s.stall%0d", n, k), 1'b1, 1'b0, xl, xd, xs);
        end
        @(negedge clk);
        drive(5'd4, 5'd3, fv, d, fl, 1'b1);
        #1;
        expect_out({n, ".go"}, 1'b1, xfr, xl, xd, xs);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            a[8*i +: 8] = 8'(i);
            b[8*i +: 8] = 8'(8'h40 + i);
            c[8*i +: 8] = 8'(8'h80 + i);
        end
        tbl.push_back(mk(5'd0, 5'd31, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 32'h0));
        tbl.push_back(mk(5'd0, 5'd31, 1'b1, a, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, a, 32'hffffffff));
        tbl.push_back(mk(5'd0, 5'd31, 1'b1, b, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, b, 32'hffffffff));
        tbl.push_back(mk(5'd0, 5'd31, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 32'h0));
        tbl.push_back(mk(5'd0, 5'd31, 1'b1, a, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, a, 32'hffffffff));
        tbl.push_back(mk(5'd0, 5'd31, 1'b1, a, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, a, 32'hffffffff));
        tbl.push_back(mk(5'd4, 5'd31, 1'b1, a, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, {a[223:0], 32'h0}, 32'hfffffff0));
        tbl.push_back(mk(5'd4, 5'd3, 1'b1, a, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, {a[223:0], 32'h0}, 32'hfffffff0));
        tbl.push_back(mk(5'd4, 5'd3, 1'b1, b, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, {b[223:0], a[255:224]}, 32'hffffffff));
        tbl.push_back(mk(5'd4, 5'd3, 1'b1, c, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, {224'h0, b[255:224]}, 32'h0000000f));
        tbl.push_back(mk(5'd4, 5'd3, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 32'h0));
        tbl.push_back(mk(5'd8, 5'd15, 1'b1, a, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, {128'h0, a[63:0], 64'h0}, 32'h0000ff00));
        tbl.push_back(mk(5'd0, 5'd7, 1'b1, b, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, {192'h0, b[63:0]}, 32'h000000ff));
        tbl.push_back(mk(5'd31, 5'd0, 1'b1, a, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, {a[7:0], 248'h0}, 32'h80000000));
        tbl.push_back(mk(5'd31, 5'd0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, {248'h0, a[15:8]}, 32'h00000001));
        tbl.push_back(mk(5'd31, 5'd0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 32'h0));
        tbl.push_back(mk(5'd4, 5'd31, 1'b1, a, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, {a[223:0], 32'h0}, 32'hfffffff0));
        tbl.push_back(mk(5'd4, 5'd31, 1'b1, b, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, {b[223:0], a[255:224]}, 32'hffffffff));
        tbl.push_back(mk(5'd4, 5'd31, 1'b1, c, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, {c[223:0], b[255:224]}, 32'hffffffff));
        tbl.push_back(mk(5'd4, 5'd31, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 32'h0));

        rst = 1'b1;
        drive(5'd0, 5'd31, 1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        expect_out("reset", 1'b0, 1'b0, 1'b0, '0, 32'h0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].s, tbl[i].e, tbl[i].fv, tbl[i].d, tbl[i].fl, tbl[i].br);
            #1;
            expect_out($sformatf("vec%0d", i), tbl[i].xbv, tbl[i].xfr, tbl[i].xl, tbl[i].xd, tbl[i].xs);
        end

        stall_beat("stall_a", 1'b1, a, 1'b0, 1'b1, 1'b0, {a[223:0], 32'h0}, 32'hfffffff0);
        stall_beat("stall_b", 1'b1, b, 1'b1, 1'b1, 1'b0, {b[223:0], a[255:224]}, 32'hffffffff);
        stall_beat("stall_flush", 1'b0, '0, 1'b0, 1'b0, 1'b1, {224'h0, b[255:224]}, 32'h0000000f);
        @(negedge clk);
        drive(5'd4, 5'd3, 1'b0, '0, 1'b0, 1'b1);
        #1;
        expect_out("stall_idle", 1'b0, 1'b1, 1'b0, '0, 32'h0);

        @(negedge clk);
        drive(5'd4, 5'd3, 1'b1, a, 1'b0, 1'b1);
        @(negedge clk);
        drive(5'd4, 5'd3, 1'b1, b, 1'b1, 1'b1);
        @(negedge clk);
        drive(5'd4, 5'd3, 1'b0, '0, 1'b0, 1'b0);
        #1;
        expect_out("pre_rst_flush", 1'b1, 1'b0, 1'b1, {224'h0, b[255:224]}, 32'h0000000f);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(5'd4, 5'd3, 1'b0, '0, 1'b0, 1'b1);
        #1;
        expect_out("post_rst", 1'b0, 1'b1, 1'b0, '0, 32'h0);
        @(negedge clk);
        drive(5'd0, 5'd31, 1'b1, c, 1'b1, 1'b1);
        #1;
        expect_out("post_rst_xfer", 1'b1, 1'b1, 1'b1, c, 32'hffffffff);
        @(negedge clk);
        drive(5'd0, 5'd31, 1'b0, '0, 1'b0, 1'b1);
        #1;
        expect_out("post_rst_idle", 1'b0, 1'b1, 1'b0, '0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/idma_data_unalign_256b.md
IDMA_DATA_UNALIGN_256B -- requirements
Module: idma_data_unalign_256b

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; the ports SHALL be clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 f_valid_in  input  1  upstream beat valid; f_data_in  input  256  dense, byte-aligned source data, byte 0 in bits [7:0]; f_data_last  input  1  final source beat.
REQ-005 f_ready_out  output  1  upstream beat accepted when high with f_valid_in.
REQ-006 b_valid_out  output  1  downstream beat valid; b_data_out  output  256  destination-aligned data; b_strb_out  output  32  byte strobes, bit i for bits [8i+7:8i]; b_data_last  output  1  final destination beat.
REQ-007 b_ready_in  input  1  downstream accepts beat.
REQ-008 start_addr  input  5  destination byte offset s of the first byte; end_addr  input  5  destination byte offset e of the last byte; both stable from first f handshake until last b handshake.

Function
REQ-009 The FSM SHALL have states IDLE (expecting first source beat), RUN, and FLUSH.
REQ-010 In IDLE and RUN: b_valid_out = f_valid_in, f_ready_out = b_ready_in, zero-cycle latency; in FLUSH: b_valid_out = 1, f_ready_out = 0.
REQ-011 spill SHALL be (s != 0) && (e < s), meaning the last source beat overflows into an extra destination beat.
REQ-012 On every f handshake, carry register SHALL load the top s bytes of f_data_in (f_data_in[255:256-8s]); carry is all-zero when s = 0.
REQ-013 In IDLE, b_data_out byte i SHALL be f_data_in byte i-s for i >= s, zero otherwise.
REQ-014 In RUN, b_data_out SHALL be {f_data_in[255-8s:0], carry} (carry fills bytes 0..s-1).
REQ-015 In FLUSH, b_data_out SHALL be carry in bytes 0..s-1, zero elsewhere.
REQ-016 Strobe SHALL be ones for all bytes, then cleared for bytes < s on the IDLE beat, and cleared for bytes > e on the last destination beat; both apply to a single-beat transfer.
REQ-017 b_data_out bytes with strobe low SHALL be zero.
REQ-018 b_data_last SHALL be high with b_valid_out when (f_data_last && !spill) in IDLE/RUN, or always in FLUSH.
REQ-019 Transitions: IDLE->RUN on f handshake with !f_data_last; IDLE/RUN->FLUSH on f handshake with f_data_last && spill; IDLE/RUN->IDLE on f handshake with f_data_last && !spill; FLUSH->IDLE on b handshake.
REQ-020 No state or carry change SHALL occur when b_ready_in is low (backpressure holds the beat; upstream keeps f_data_in stable).
REQ-021 s = 0 SHALL give pass-through data with strobes from e only; FLUSH never entered.

Reset
REQ-022 On rst: state = IDLE, carry = 0; b_valid_out, b_data_last, f_ready_out follow REQ-010/018 from IDLE (low when inputs low); reset mid-transfer SHALL abandon the transfer without an extra beat.

Configuration
REQ-023 Macro IDMA_UNALIGN_BYTECNT_EN: when defined, output b_byte_cnt[15:0] SHALL count strobed bytes on b handshakes, clearing on rst and on the first b handshake of a transfer (load with its popcount); when undefined the port and counter SHALL not exist.

Verification
REQ-024 s=0,e=31, 2 beats A,B -> 2 beats A,B, strb FFFFFFFF, last on beat 2, no FLUSH.
REQ-025 s=4,e=31, 1 beat A -> 1 beat {A[223:0],32'h0}, strb FFFFFFF0, last high.
REQ-026 s=4,e=3, 2 beats A,B -> {A[223:0],0} strb FFFFFFF0; {B[223:0],A[255:224]} strb FFFFFFFF; flush {0,B[255:224]} strb 0000000F last; f_ready_out low during flush.
REQ-027 s=8,e=15, 1 beat A -> 1 beat A[63:0] at bytes 8..15, strb 0000FF00, last high.
REQ-028 scenario REQ-026 with b_ready_in low 3 cycles on each beat -> identical beats, each held stable while stalled.
REQ-029 rst asserted in FLUSH -> next cycle IDLE, b_valid_out low; new transfer s=0 passes cleanly.
